branch_resolve_unit: RTL

Resolves conditional branches in EX against the 2-bit predictor's ID-stage guess and produces the one-cycle `update`/`taken` training pulse that feeds the predictor. It also issues the pipeline flush and redirect PC on a misprediction and keeps saturating branch and mispredict counters for performance readout. It sits downstream of the predictor, between the ID/EX and EX/MEM pipeline registers.

---
 rtl/branch_resolve_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves the conditional branch held in the EX slot against the 2-bit
// predictor's ID-stage guess. Produces the one-cycle update/taken training
// pulse, the flush pulse and redirect PC on a misprediction, and saturating
// branch / mispredict performance counters. Every output is registered.
//
// Ports:
//   clk             core clock, rising edge
//   rst             asynchronous, active-high reset
//   stall           pipeline hold; EX slot freezes, no resolution
//   id_is_branch    ID instruction is a conditional branch
//   id_pc           PC of the ID instruction
//   id_target       branch target of the ID instruction
//   branch_predict  predictor guess for the ID branch (1 = taken)
//   ex_cond         actual branch condition for the EX instruction
//   update          one-cycle predictor training pulse
//   taken           resolved outcome accompanying update
//   flush           one-cycle kill/refetch pulse
//   redirect_pc     correct next PC, valid while flush = 1
//   branch_cnt      resolved branches, saturating
//   mispredict_cnt  mispredicted branches, saturating
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 id_is_branch,
  input  logic [PC_WIDTH-1:0]  id_pc,
  input  logic [PC_WIDTH-1:0]  id_target,
  input  logic                 branch_predict,
  input  logic                 ex_cond,
  output logic                 update,
  output logic                 taken,
  output logic                 flush,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam logic [PC_WIDTH-1:0]  PC_STEP = PC_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Saturating increment: a counter at all-ones stays there.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    if (cnt == CNT_MAX) begin
      return cnt;
    end else begin
      return cnt + CNT_WIDTH'(1);
    end
  endfunction

  logic                ex_valid_r;
  logic                ex_pred_r;
  logic [PC_WIDTH-1:0] ex_pc_r;
  logic [PC_WIDTH-1:0] ex_target_r;

  logic                resolve_s;
  logic                mispredict_s;
  logic                kill_s;
  logic [PC_WIDTH-1:0] next_pc_s;

  // Resolution decode and wrong-path kill for the instruction entering EX.
  always_comb begin
    resolve_s    = 1'b0;
    mispredict_s = 1'b0;
    kill_s       = 1'b0;
    next_pc_s    = ex_pc_r + PC_STEP;
    if (ex_valid_r && !stall) begin
      resolve_s    = 1'b1;
      mispredict_s = (ex_cond != ex_pred_r);
    end else begin
      resolve_s    = 1'b0;
      mispredict_s = 1'b0;
    end
    // The ID instruction is wrong-path both in the mispredict cycle and
    // in the following flush cycle.
    kill_s = mispredict_s | flush;
    if (ex_cond) begin
      next_pc_s = ex_target_r;
    end else begin
      next_pc_s = ex_pc_r + PC_STEP;
    end
  end

  // EX slot: capture from ID when not stalled, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r  <= 1'b0;
      ex_pred_r   <= 1'b0;
      ex_pc_r     <= '0;
      ex_target_r <= '0;
    end else if (!stall) begin
      ex_valid_r  <= id_is_branch & ~kill_s;
      ex_pred_r   <= branch_predict;
      ex_pc_r     <= id_pc;
      ex_target_r <= id_target;
    end else begin
      ex_valid_r  <= ex_valid_r;
      ex_pred_r   <= ex_pred_r;
      ex_pc_r     <= ex_pc_r;
      ex_target_r <= ex_target_r;
    end
  end

  // Registered training, flush and redirect outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update      <= 1'b0;
      taken       <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      update <= resolve_s;
      taken  <= resolve_s & ex_cond;
      flush  <= mispredict_s;
      // redirect_pc only changes alongside a flush pulse.
      if (mispredict_s) begin
        redirect_pc <= next_pc_s;
      end else begin
        redirect_pc <= redirect_pc;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (resolve_s) begin
        branch_cnt <= sat_inc(branch_cnt);
      end else begin
        branch_cnt <= branch_cnt;
      end
      if (mispredict_s) begin
        mispredict_cnt <= sat_inc(mispredict_cnt);
      end else begin
        mispredict_cnt <= mispredict_cnt;
      end
    end
  end

endmodule
